// File: rtl/riscv_pkg.sv
// Shared types for the ID/EX operand stage: ALU op codes, forward selects,
// and the registered ID/EX payload.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int OPW  = 4;
  localparam int REGW = 5;

  typedef enum logic [OPW-1:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_SLTI = 4'b0011,
    OP_XOR  = 4'b0101,
    OP_SUB  = 4'b0110,
    OP_SLT  = 4'b0111,
    OP_EQ   = 4'b1000,
    OP_ADDI = 4'b1100
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_NONE  = 2'd0,
    FWD_MEMWB = 2'd1,
    FWD_EXMEM = 2'd2
  } fwd_sel_e;

  // alu_op kept as raw bits so any decoded code passes through untouched
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [REGW-1:0] rs1;
    logic [REGW-1:0] rs2;
    logic [REGW-1:0] rd;
    logic [OPW-1:0]  alu_op;
    logic            src_a_pc;
    logic            src_b_imm;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
  } id_ex_t;

  function automatic id_ex_t bubble();
    id_ex_t b;
    b        = '0;
    b.alu_op = OP_AND;
    return b;
  endfunction

endpackage

// File: rtl/id_ex_operand_stage_fwd_unit.sv
// Forward-select generator for one source register; EX/MEM beats MEM/WB,
// and x0 is never forwarded.
module fwd_unit
  import riscv_pkg::*;
#(
  parameter int REG_ADDR_W = REGW
) (
  input  logic [REG_ADDR_W-1:0] src_i,
  input  logic [REG_ADDR_W-1:0] exmem_rd,
  input  logic                  exmem_reg_write,
  input  logic [REG_ADDR_W-1:0] memwb_rd,
  input  logic                  memwb_reg_write,
  output fwd_sel_e              sel_o
);

  logic src_nz_s;

  assign src_nz_s = (src_i != {REG_ADDR_W{1'b0}});

  // Priority select of the forwarding source
  always_comb begin
    sel_o = FWD_NONE;
    if (src_nz_s && exmem_reg_write && (exmem_rd == src_i)) begin
      sel_o = FWD_EXMEM;
    end else if (src_nz_s && memwb_reg_write && (memwb_rd == src_i)) begin
      sel_o = FWD_MEMWB;
    end else begin
      sel_o = FWD_NONE;
    end
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with RAW forwarding and load-use detection,
// feeding SrcA/SrcB/Operation directly into the ALU.
module id_ex_operand_stage
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH    = XLEN,
  parameter int OPCODE_LENGTH = OPW,
  parameter int REG_ADDR_W    = REGW
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     id_valid,
  input  logic [DATA_WIDTH-1:0]    id_pc,
  input  logic [DATA_WIDTH-1:0]    id_rs1_data,
  input  logic [DATA_WIDTH-1:0]    id_rs2_data,
  input  logic [DATA_WIDTH-1:0]    id_imm,
  input  logic [REG_ADDR_W-1:0]    id_rs1,
  input  logic [REG_ADDR_W-1:0]    id_rs2,
  input  logic [REG_ADDR_W-1:0]    id_rd,
  input  logic [OPCODE_LENGTH-1:0] id_alu_op,
  input  logic                     id_src_a_pc,
  input  logic                     id_src_b_imm,
  input  logic                     id_reg_write,
  input  logic                     id_mem_read,
  input  logic                     id_mem_write,
  input  logic                     stall,
  input  logic                     flush,
  input  logic [REG_ADDR_W-1:0]    exmem_rd,
  input  logic [REG_ADDR_W-1:0]    memwb_rd,
  input  logic                     exmem_reg_write,
  input  logic                     memwb_reg_write,
  input  logic [DATA_WIDTH-1:0]    exmem_result,
  input  logic [DATA_WIDTH-1:0]    memwb_result,
  output logic [DATA_WIDTH-1:0]    SrcA,
  output logic [DATA_WIDTH-1:0]    SrcB,
  output logic [OPCODE_LENGTH-1:0] Operation,
  output logic [DATA_WIDTH-1:0]    ex_store_data,
  output logic                     ex_valid,
  output logic [REG_ADDR_W-1:0]    ex_rd,
  output logic                     ex_reg_write,
  output logic                     ex_mem_read,
  output logic                     ex_mem_write,
  output logic [DATA_WIDTH-1:0]    ex_pc,
  output logic                     load_use_hazard
);

  id_ex_t                ex_q;
  id_ex_t                ex_d;
  fwd_sel_e              rs1_sel_s;
  fwd_sel_e              rs2_sel_s;
  logic [DATA_WIDTH-1:0] fwd_rs1_s;
  logic [DATA_WIDTH-1:0] fwd_rs2_s;

  // Next ID/EX contents: flush > stall > load; an invalid slot loads as a bubble
  always_comb begin
    ex_d = ex_q;
    if (flush) begin
      ex_d = bubble();
    end else if (stall) begin
      ex_d = ex_q;
    end else begin
      ex_d.valid     = id_valid;
      ex_d.pc        = id_pc;
      ex_d.rs1_data  = id_rs1_data;
      ex_d.rs2_data  = id_rs2_data;
      ex_d.imm       = id_imm;
      ex_d.rs1       = id_rs1;
      ex_d.rs2       = id_rs2;
      ex_d.rd        = id_valid ? id_rd : {REG_ADDR_W{1'b0}};
      ex_d.alu_op    = id_alu_op;
      ex_d.src_a_pc  = id_src_a_pc;
      ex_d.src_b_imm = id_src_b_imm;
      ex_d.reg_write = id_valid & id_reg_write;
      ex_d.mem_read  = id_valid & id_mem_read;
      ex_d.mem_write = id_valid & id_mem_write;
    end
  end

  // ID/EX register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  fwd_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_rs1 (
    .src_i           (ex_q.rs1),
    .exmem_rd        (exmem_rd),
    .exmem_reg_write (exmem_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_reg_write (memwb_reg_write),
    .sel_o           (rs1_sel_s)
  );

  fwd_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_rs2 (
    .src_i           (ex_q.rs2),
    .exmem_rd        (exmem_rd),
    .exmem_reg_write (exmem_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_reg_write (memwb_reg_write),
    .sel_o           (rs2_sel_s)
  );

  // Forwarded rs1 value
  always_comb begin
    fwd_rs1_s = ex_q.rs1_data;
    case (rs1_sel_s)
      FWD_EXMEM: fwd_rs1_s = exmem_result;
      FWD_MEMWB: fwd_rs1_s = memwb_result;
      FWD_NONE:  fwd_rs1_s = ex_q.rs1_data;
      default:   fwd_rs1_s = ex_q.rs1_data;
    endcase
  end

  // Forwarded rs2 value
  always_comb begin
    fwd_rs2_s = ex_q.rs2_data;
    case (rs2_sel_s)
      FWD_EXMEM: fwd_rs2_s = exmem_result;
      FWD_MEMWB: fwd_rs2_s = memwb_result;
      FWD_NONE:  fwd_rs2_s = ex_q.rs2_data;
      default:   fwd_rs2_s = ex_q.rs2_data;
    endcase
  end

  assign SrcA          = ex_q.src_a_pc  ? ex_q.pc  : fwd_rs1_s;
  assign SrcB          = ex_q.src_b_imm ? ex_q.imm : fwd_rs2_s;
  assign ex_store_data = fwd_rs2_s;
  assign Operation     = ex_q.alu_op;
  assign ex_valid      = ex_q.valid;
  assign ex_rd         = ex_q.rd;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_mem_read   = ex_q.mem_read;
  assign ex_mem_write  = ex_q.mem_write;
  assign ex_pc         = ex_q.pc;

  assign load_use_hazard = ex_q.valid && ex_q.mem_read &&
                           (ex_q.rd != {REG_ADDR_W{1'b0}}) &&
                           ((ex_q.rd == id_rs1) || (ex_q.rd == id_rs2));

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Randomized and directed bench for id_ex_operand_stage against a small
// pipeline-slot model.
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid, id_src_a_pc, id_src_b_imm, id_reg_write, id_mem_read, id_mem_write;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [3:0]  id_alu_op;
  logic        stall, flush;
  logic [4:0]  exmem_rd, memwb_rd;
  logic        exmem_reg_write, memwb_reg_write;
  logic [31:0] exmem_result, memwb_result;
  logic [31:0] SrcA, SrcB, ex_store_data, ex_pc;
  logic [3:0]  Operation;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, load_use_hazard;
  logic [4:0]  ex_rd;

  int n_checks = 0;
  int n_errors = 0;

  // Model of the instruction currently sitting in EX
  logic        m_valid, m_a_pc, m_b_imm, m_rw, m_mr, m_mw;
  logic [31:0] m_pc, m_rs1d, m_rs2d, m_imm;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic [3:0]  m_op;

  id_ex_operand_stage dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_op(id_alu_op),
    .id_src_a_pc(id_src_a_pc), .id_src_b_imm(id_src_b_imm),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .stall(stall), .flush(flush), .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
    .exmem_reg_write(exmem_reg_write), .memwb_reg_write(memwb_reg_write),
    .exmem_result(exmem_result), .memwb_result(memwb_result),
    .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation), .ex_store_data(ex_store_data),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_pc(ex_pc),
    .load_use_hazard(load_use_hazard)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fwd_val(input logic [4:0] s, input logic [31:0] file_val);
    if (s != 5'd0 && exmem_reg_write && exmem_rd == s) return exmem_result;
    if (s != 5'd0 && memwb_reg_write && memwb_rd == s) return memwb_result;
    return file_val;
  endfunction

  task automatic model_clear();
    {m_valid, m_a_pc, m_b_imm, m_rw, m_mr, m_mw} = 6'd0;
    {m_pc, m_rs1d, m_rs2d, m_imm} = 128'd0;
    {m_rs1, m_rs2, m_rd} = 15'd0;
    m_op = 4'b0000;
  endtask

  task automatic model_edge();
    if (flush) begin
      model_clear();
    end else if (!stall) begin
      m_valid = id_valid; m_pc = id_pc; m_rs1d = id_rs1_data; m_rs2d = id_rs2_data;
      m_imm = id_imm; m_rs1 = id_rs1; m_rs2 = id_rs2; m_op = id_alu_op;
      m_a_pc = id_src_a_pc; m_b_imm = id_src_b_imm;
      m_rd = id_valid ? id_rd : 5'd0;
      m_rw = id_valid && id_reg_write;
      m_mr = id_valid && id_mem_read;
      m_mw = id_valid && id_mem_write;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_all(input string tag);
    logic [31:0] f1, f2;
    logic        hz;
    f1 = fwd_val(m_rs1, m_rs1d);
    f2 = fwd_val(m_rs2, m_rs2d);
    hz = m_valid && m_mr && m_rd != 5'd0 && (m_rd == id_rs1 || m_rd == id_rs2);
    check_eq({tag, ".srca"},  SrcA, m_a_pc ? m_pc : f1);
    check_eq({tag, ".srcb"},  SrcB, m_b_imm ? m_imm : f2);
    check_eq({tag, ".store"}, ex_store_data, f2);
    check_eq({tag, ".op"},    {28'd0, Operation}, {28'd0, m_op});
    check_eq({tag, ".ctl"},   {26'd0, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, load_use_hazard, 1'b0},
                              {26'd0, m_valid, m_rw, m_mr, m_mw, hz, 1'b0});
    check_eq({tag, ".rd"},    {27'd0, ex_rd}, {27'd0, m_rd});
    check_eq({tag, ".pc"},    ex_pc, m_pc);
  endtask

  task automatic idle_inputs();
    {id_valid, id_src_a_pc, id_src_b_imm, id_reg_write, id_mem_read, id_mem_write} = 6'd0;
    {id_pc, id_rs1_data, id_rs2_data, id_imm} = 128'd0;
    {id_rs1, id_rs2, id_rd} = 15'd0;
    id_alu_op = 4'b0000;
    stall = 1'b0; flush = 1'b0;
    exmem_rd = 5'd0; memwb_rd = 5'd0;
    exmem_reg_write = 1'b0; memwb_reg_write = 1'b0;
    exmem_result = 32'd0; memwb_result = 32'd0;
  endtask

  task automatic load_instr(input logic [4:0] rs1, input logic [31:0] d1,
                            input logic [4:0] rs2, input logic [31:0] d2,
                            input logic [4:0] rd, input logic [3:0] op);
    id_valid = 1'b1; id_rs1 = rs1; id_rs1_data = d1; id_rs2 = rs2; id_rs2_data = d2;
    id_rd = rd; id_alu_op = op; id_reg_write = 1'b1; id_pc = 32'h0000_1000;
  endtask

  initial begin
    idle_inputs();
    model_clear();
    reset = 1'b0;
    #12;
    check_all("reset");
    check_eq("reset.srca", SrcA, 32'd0);
    reset = 1'b1;
    cycle();

    // ADD x3, x1(10), x2(5)
    load_instr(5'd1, 32'd10, 5'd2, 32'd5, 5'd3, 4'b0010);
    cycle();
    idle_inputs();
    #1;
    check_eq("add.srca", SrcA, 32'd10);
    check_eq("add.srcb", SrcB, 32'd5);
    check_eq("add.op", {28'd0, Operation}, 32'd2);
    check_all("add");

    // Forwarding priority on rs1=x1
    exmem_rd = 5'd1; exmem_reg_write = 1'b1; exmem_result = 32'd99;
    memwb_rd = 5'd1; memwb_reg_write = 1'b1; memwb_result = 32'd7;
    #1;
    check_eq("fwd.exmem", SrcA, 32'd99);
    exmem_reg_write = 1'b0;
    #1;
    check_eq("fwd.memwb", SrcA, 32'd7);
    check_all("fwd");

    // x0 source with x0 destinations is never forwarded
    load_instr(5'd0, 32'h55, 5'd0, 32'h66, 5'd4, 4'b0001);
    cycle();
    exmem_rd = 5'd0; exmem_reg_write = 1'b1; exmem_result = 32'hDEAD;
    memwb_rd = 5'd0; memwb_reg_write = 1'b1; memwb_result = 32'hBEEF;
    #1;
    check_eq("fwd.x0", SrcA, 32'h55);
    check_all("x0");

    // Asynchronous reset mid-cycle while stalled with loaded regs
    stall = 1'b1;
    #1;
    reset = 1'b0;
    #1;
    model_clear();
    check_eq("areset.op", {28'd0, Operation}, 32'd0);
    check_eq("areset.srca", SrcA, 32'd0);
    check_all("areset");
    reset = 1'b1;
    idle_inputs();
    cycle();

    // Load-use: LW x3 in EX, decode reads x3 as rs2
    load_instr(5'd1, 32'd100, 5'd0, 32'd0, 5'd3, 4'b0010);
    id_mem_read = 1'b1; id_src_b_imm = 1'b1; id_imm = 32'd8;
    cycle();
    idle_inputs();
    id_rs1 = 5'd7; id_rs2 = 5'd3;
    #1;
    check_eq("lu.hazard", {31'd0, load_use_hazard}, 32'd1);
    check_all("lu");
    flush = 1'b1;
    id_valid = 1'b1; id_reg_write = 1'b1; id_rd = 5'd9;
    cycle();
    check_eq("lu.valid", {31'd0, ex_valid}, 32'd0);
    check_eq("lu.rw", {31'd0, ex_reg_write}, 32'd0);
    check_all("lu_flush");
    idle_inputs();

    // Stall for 3 cycles while ID inputs change
    load_instr(5'd5, 32'h1234, 5'd6, 32'h5678, 5'd7, 4'b0110);
    cycle();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      id_rs1_data = $urandom; id_rs2_data = $urandom; id_alu_op = 4'($urandom);
      id_rd = 5'($urandom); id_pc = $urandom;
      cycle();
      check_eq("stall.srca", SrcA, 32'h1234);
      check_eq("stall.op", {28'd0, Operation}, 32'd6);
      check_all("stall");
    end
    flush = 1'b1;
    cycle();
    check_eq("stflush.valid", {31'd0, ex_valid}, 32'd0);
    check_all("stall_flush");
    idle_inputs();

    // ADDI with imm=-4 and rs2 forwarded from EX/MEM
    load_instr(5'd4, 32'd3, 5'd5, 32'h11, 5'd4, 4'b1100);
    id_src_b_imm = 1'b1; id_imm = 32'hFFFF_FFFC; id_mem_write = 1'b1;
    cycle();
    idle_inputs();
    exmem_rd = 5'd5; exmem_reg_write = 1'b1; exmem_result = 32'h0000_ABCD;
    #1;
    check_eq("addi.srcb", SrcB, 32'hFFFF_FFFC);
    check_eq("addi.store", ex_store_data, 32'h0000_ABCD);
    check_all("addi");

    // Randomized traffic with small register indices to provoke hits
    for (int i = 0; i < 400; i++) begin
      id_valid = 1'($urandom); id_pc = $urandom; id_rs1_data = $urandom;
      id_rs2_data = $urandom; id_imm = $urandom;
      id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
      id_rd = 5'($urandom_range(0, 3)); id_alu_op = 4'($urandom);
      id_src_a_pc = 1'($urandom); id_src_b_imm = 1'($urandom);
      id_reg_write = 1'($urandom); id_mem_read = 1'($urandom); id_mem_write = 1'($urandom);
      stall = ($urandom_range(0, 4) == 0); flush = ($urandom_range(0, 6) == 0);
      cycle();
      exmem_rd = 5'($urandom_range(0, 3)); memwb_rd = 5'($urandom_range(0, 3));
      exmem_reg_write = 1'($urandom); memwb_reg_write = 1'($urandom);
      exmem_result = $urandom; memwb_result = $urandom;
      #1;
      check_all("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
